// File: rtl/wptr_full_if.sv
// Write-side bus of an async FIFO: write request, memory strobe/address,
// the Gray pointers exchanged with the read domain, and occupancy flags.
interface wptr_full_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr_async;
    logic                wen;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wcount;
    logic                woverflow;

    // Handshake: a write is taken on a wclk edge where winc=1 and wfull=0;
    // wen mirrors that acceptance combinationally, so winc while full is dropped.
    modport master (
        output winc, rptr_async,
        input  wen, waddr, wptr, wfull, wafull, wcount, woverflow
    );

    modport slave (
        input  winc, rptr_async,
        output wen, waddr, wptr, wfull, wafull, wcount, woverflow
    );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-pointer and full/almost-full logic, with a two-flop
// synchronizer for the Gray read pointer arriving from the read domain.
module wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
    input  logic         wclk,
    input  logic         wrst,
    wptr_full_if.slave   bus
);
    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbnext;
    logic [ADDRSIZE:0] wgnext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] occ_next;
    logic              winc_ok;

    assign winc_ok   = bus.winc & ~bus.wfull & ~wrst;
    assign bus.wen   = winc_ok;
    assign bus.waddr = wbin[ADDRSIZE-1:0];

    assign wbnext   = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
    assign wgnext   = (wbnext >> 1) ^ wbnext;
    assign occ_next = wbnext - rbin_s;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wq1_rptr      <= '0;
            wq2_rptr      <= '0;
            wbin          <= '0;
            bus.wptr      <= '0;
            bus.wfull     <= 1'b0;
            bus.wafull    <= 1'b0;
            bus.wcount    <= '0;
            bus.woverflow <= 1'b0;
        end else begin
            wq1_rptr   <= bus.rptr_async;
            wq2_rptr   <= wq1_rptr;
            wbin       <= wbnext;
            bus.wptr   <= wgnext;
            // Full when the write pointer has lapped the read pointer exactly once.
            bus.wfull  <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                       wq2_rptr[ADDRSIZE-2:0]});
            bus.wcount <= occ_next;
            bus.wafull <= (occ_next >= AFULL_LVL);
            if (bus.winc & bus.wfull) begin
                bus.woverflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed fill/overflow/drain/wrap/reset
// sequences followed by random writes and read-pointer advances.
module tb_wptr_full;
  localparam int AS = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int W = 19;

  logic wclk;
  logic wrst;
  wptr_full_if #(.ADDRSIZE(AS)) bus ();

  wptr_full #(.ADDRSIZE(AS), .AFULL_THRESH(AF)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  // clock / reset
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // reference model state: counts of items, not pointer encodings
  int m_wr;      // total writes accepted since reset
  int m_s1;      // read count seen by the first synchronizer stage
  int m_s2;      // read count seen by the second synchronizer stage
  bit m_full;
  bit m_afull;
  bit m_ovf;
  int m_cnt;
  int rd_tot;    // read count currently presented on rptr_async

  logic [W-1:0] exp_q[$];
  int tests;
  int fails;
  bit drv_done;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // driver: one cycle of stimulus plus the model's prediction for it
  task automatic drive(input bit r, input bit w, input int rd);
    bit e_wen;
    bit acc;
    int occ;
    logic [3:0] e_addr;
    @(negedge wclk);
    wrst = r;
    bus.winc = w;
    rd_tot = rd;
    bus.rptr_async = gray(rd);
    e_wen  = w & !m_full & !r;
    e_addr = 4'(m_wr % DEPTH);
    if (r) begin
      m_wr = 0; m_s1 = 0; m_s2 = 0;
      m_full = 0; m_afull = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      acc = w & !m_full;
      if (w && m_full) m_ovf = 1;
      if (acc) m_wr++;
      occ = ((m_wr - m_s2) % 32 + 32) % 32;
      m_cnt = occ;
      m_full = (occ == DEPTH);
      m_afull = (occ >= AF);
      m_s2 = m_s1;
      m_s1 = rd;
    end
    exp_q.push_back({!r, e_wen, e_addr, gray(m_wr), m_full, m_afull, 5'(m_cnt), m_ovf});
  endtask

  // monitor: pops one expectation per cycle; combinational outputs are
  // sampled after the inputs settle, registered outputs just after the edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge wclk);
      #2;
      if (exp_q.size() == 0) begin
        if (!drv_done) begin
          tests++; fails++;
          $display("FAIL monitor_starve at %0t: got empty queue, expected an entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("wen", 8'(bus.wen), 8'(e[17]));
        if (e[18]) check("waddr", 8'(bus.waddr), 8'(e[16:13]));
        @(posedge wclk);
        #1;
        check("wptr",      8'(bus.wptr),      8'(e[12:8]));
        check("wfull",     8'(bus.wfull),     8'(e[7]));
        check("wafull",    8'(bus.wafull),    8'(e[6]));
        check("wcount",    8'(bus.wcount),    8'(e[5:1]));
        check("woverflow", 8'(bus.woverflow), 8'(e[0]));
      end
    end
  end

  initial begin
    int budget;
    tests = 0; fails = 0; drv_done = 0;
    m_wr = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_cnt = 0;
    rd_tot = 0;
    wrst = 1'b1;
    bus.winc = 1'b0;
    bus.rptr_async = '0;

    // reset with winc held high
    drive(1, 1, 0);
    drive(1, 1, 0);
    // fill to full, then overflow attempts
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    drive(0, 0, 0);
    // drain one slot: flag clears on the third edge
    for (int i = 0; i < 5; i++) drive(0, 0, 1);
    // wrap: fresh fill, read pointer jumps to 16, then one more write
    drive(1, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 16);
    drive(0, 1, 16);
    drive(0, 0, 16);
    // reset in the middle of a burst
    drive(1, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 0);
    drive(1, 1, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    // random traffic; read count never overtakes accepted writes
    for (int i = 0; i < 2000; i++) begin
      int rd;
      rd = rd_tot;
      if ($urandom_range(0, 199) == 0) begin
        drive(1, 1'($urandom_range(0, 1)), 0);
      end else begin
        if (rd < m_wr && $urandom_range(0, 99) < 45) rd++;
        drive(0, ($urandom_range(0, 99) < 60), rd);
      end
    end
    drv_done = 1;

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge wclk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    repeat (2) @(posedge wclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: address width; FIFO depth = 2**ADDRSIZE.
REQ-002 SHALL have parameter AFULL_THRESH, default 2**ADDRSIZE-2: occupancy at or above which wafull asserts.
REQ-003 SHALL have port wclk  input  1  write-domain clock; all state on rising edge.
REQ-004 SHALL have port wrst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port winc  input  1  write request.
REQ-006 SHALL have port rptr_async  input  ADDRSIZE+1  Gray read pointer from read domain, unsynchronized.
REQ-007 SHALL have port wen  output  1  memory write enable.
REQ-008 SHALL have port waddr  output  ADDRSIZE  memory write address.
REQ-009 SHALL have port wptr  output  ADDRSIZE+1  registered Gray write pointer, to read domain.
REQ-010 SHALL have port wfull  output  1  registered full flag.
REQ-011 SHALL have port wafull  output  1  registered almost-full flag.
REQ-012 SHALL have port wcount  output  ADDRSIZE+1  registered occupancy as seen by the write side.
REQ-013 SHALL have port woverflow  output  1  sticky write-while-full flag.

Function
REQ-014 SHALL pass rptr_async through a two-stage flop synchronizer (wq1_rptr, then wq2_rptr); only wq2_rptr is used downstream.
REQ-015 SHALL hold binary pointer wbin (ADDRSIZE+1 bits); wbnext = wbin + (winc & !wfull), wrapping modulo 2**(ADDRSIZE+1).
REQ-016 SHALL compute wgnext = (wbnext >> 1) ^ wbnext; wptr <= wgnext and wbin <= wbnext every edge.
REQ-017 SHALL drive waddr = wbin[ADDRSIZE-1:0] and wen = winc & !wfull, both combinational.
REQ-018 SHALL register wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
REQ-019 SHALL convert wq2_rptr from Gray to binary (rbin_s) and register wcount <= wbnext - rbin_s, modulo 2**(ADDRSIZE+1).
REQ-020 SHALL register wafull <= ((wbnext - rbin_s) >= AFULL_THRESH).
REQ-021 SHALL set woverflow on any edge with winc & wfull; it clears only on reset.
REQ-022 SHALL ignore a write while full: no wen, no pointer or count change.
REQ-023 SHALL assert wfull on the same edge that accepts the write filling the last slot.
REQ-024 SHALL deassert wfull on the third rising edge after a change in rptr_async: two synchronizer stages plus the flag register.
REQ-025 SHALL let a write and a read-pointer update in the same cycle both take effect; wcount reflects both once the read update is synchronized.

Reset
REQ-026 SHALL, while wrst=1 at a rising edge, clear wbin, wptr, wq1_rptr, wq2_rptr, wcount, wfull, wafull and woverflow to 0.
REQ-027 SHALL ignore winc during reset; wen is forced 0 in any cycle where wrst=1.
REQ-028 SHALL have no reset path other than wrst at the wclk edge.

Verification (ADDRSIZE=4, AFULL_THRESH=14)
REQ-029 Reset: wrst=1 for 1 cycle with winc=1 -> all outputs 0 and wen=0 after the edge.
REQ-030 Fill: rptr_async=0, 16 consecutive winc -> waddr 0..15, wafull=1 after the 14th write, wfull=1 and wcount=16 after the 16th.
REQ-031 Overflow: a 17th winc while full -> wen=0, wptr stays 5'b11000, woverflow=1 and remains set.
REQ-032 Drain: from full, rptr_async 0 -> 5'b00001 -> wfull=0 and wcount=15 on the 3rd edge, not before.
REQ-033 Wrap: after 16 writes, rptr_async=5'b11000 (binary 16) then one write -> wptr=5'b11001, waddr=1, wcount=1, wfull=0.
REQ-034 Mid-run reset: wrst=1 during a write burst at wcount=7 -> next edge wcount=0, wptr=0, flags 0, no increment.
